lsu_mc: RTL and testbench

- Multi-cycle load/store unit. Replaces the direct ALU-result-to-RAM path and the MDR path of the multi-cycle core.
- Accepts one load/store request from the control unit. Drives a variable-latency data-memory port with byte enables. Returns sign- or zero-extended load data in a single response pulse.
- Parametrised in data width and address width. Supports wait states, and optionally splits misaligned accesses into two memory beats.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_lane_align.sv | 45 ++++
 rtl/lsu_mc.sv | 119 +++++++++++
 tb/tb_lsu_mc.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM states and helpers for the multi-cycle load/store unit.
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic [3:0] bytes_of(input logic [1:0] size);
    return 4'd1 << size;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane enables, write-data lane shift and read-data assembly/extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]                 size_i,
  input  logic [$clog2(XLEN/8)-1:0]  off_i,
  input  logic                       se_i,
  input  logic [XLEN-1:0]            wdata_i,
  input  logic [2*XLEN-1:0]          rbuf_i,
  output logic [XLEN/8-1:0]          be_lo_o,
  output logic [XLEN/8-1:0]          be_hi_o,
  output logic [XLEN-1:0]            wd_lo_o,
  output logic [XLEN-1:0]            wd_hi_o,
  output logic [XLEN-1:0]            rdata_o
);
  localparam int BYTES = XLEN/8;

  logic [2*BYTES-1:0] mask;
  logic [2*XLEN-1:0]  wide;
  logic [2*XLEN-1:0]  rsh;
  logic [XLEN-1:0]    low;
  logic [XLEN-1:0]    keep;
  logic [XLEN-1:0]    top;
  logic               sign;

  // The access is viewed as a two-word window: the high half is the second beat of a split access.
  always_comb begin
    mask    = (((2*BYTES)'(1) << bytes_of(size_i)) - (2*BYTES)'(1)) << off_i;
    wide    = {{XLEN{1'b0}}, wdata_i} << {off_i, 3'b000};
    rsh     = rbuf_i >> {off_i, 3'b000};
    low     = rsh[XLEN-1:0];
    keep    = size_i == SZ_B ? XLEN'(8'hFF) :
              size_i == SZ_H ? XLEN'(16'hFFFF) :
              size_i == SZ_W ? XLEN'(32'hFFFF_FFFF) : '1;
    top     = keep & ~(keep >> 1);
    sign    = se_i & (|(low & top));
    rdata_o = (low & keep) | ({XLEN{sign}} & ~keep);
    be_lo_o = mask[BYTES-1:0];
    be_hi_o = mask[2*BYTES-1:BYTES];
    wd_lo_o = wide[XLEN-1:0];
    wd_hi_o = wide[2*XLEN-1:XLEN];
  end
endmodule

// File: rtl/lsu_mc.sv
// lsu_mc: multi-cycle load/store unit driving a variable-latency byte-enabled memory port.
// Define LSU_MISALIGN_SPLIT_EN to run boundary-crossing accesses as two beats instead of faulting.
module lsu_mc
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_se,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_fault,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_ack
);
  localparam int BYTES = XLEN/8;
  localparam int OW    = $clog2(BYTES);
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  state_e              state_q, state_d;
  logic                we_q, se_q, fault_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [XLEN-1:0]     wdata_q;
  logic [2*XLEN-1:0]   rbuf_q;
  logic [4:0]          span;
  logic                bad, b0, b1;
  logic [ADDR_W-1:0]   base;
  logic [BYTES-1:0]    be_lo, be_hi;
  logic [XLEN-1:0]     wd_lo, wd_hi, ext;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .size_i  (size_q),
    .off_i   (addr_q[OW-1:0]),
    .se_i    (se_q),
    .wdata_i (wdata_q),
    .rbuf_i  (rbuf_q),
    .be_lo_o (be_lo),
    .be_hi_o (be_hi),
    .wd_lo_o (wd_lo),
    .wd_hi_o (wd_hi),
    .rdata_o (ext)
  );

  always_comb begin
    req_ready = state_q == ST_IDLE && !rst_;
    span      = 5'(req_addr[OW-1:0]) + 5'(bytes_of(req_size));
    bad       = (req_size == SZ_D && XLEN == 32) || (span > 5'(BYTES) && !SPLIT);
    state_d   = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = bad ? ST_RESP : ST_BEAT0;
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_BEAT0: if (mem_ack) state_d = |be_hi ? ST_BEAT1 : ST_RESP;
      ST_BEAT1: if (mem_ack) state_d = ST_RESP;
`else
      ST_BEAT0: if (mem_ack) state_d = ST_RESP;
`endif
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      se_q    <= 1'b0;
      fault_q <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      if (req_ready && req_valid) begin
        we_q    <= req_we;
        se_q    <= req_se;
        fault_q <= bad;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == ST_BEAT0 && mem_ack) rbuf_q[XLEN-1:0] <= mem_rdata;
      if (state_q == ST_BEAT1 && mem_ack) rbuf_q[2*XLEN-1:XLEN] <= mem_rdata;
    end
  end

  // Beat outputs are pure functions of the state and latched request, so they hold until mem_ack.
  always_comb begin
    b0        = state_q == ST_BEAT0;
    b1        = state_q == ST_BEAT1;
    base      = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
    mem_req   = b0 || b1;
    mem_we    = mem_req && we_q;
    mem_addr  = b0 ? base : b1 ? base + ADDR_W'(BYTES) : '0;
    mem_be    = b0 ? be_lo : b1 ? be_hi : '0;
    mem_wdata = b0 ? wd_lo : b1 ? wd_hi : '0;
    rsp_valid = state_q == ST_RESP;
    rsp_fault = rsp_valid && fault_q;
    rsp_rdata = rsp_valid && !we_q && !fault_q ? ext : '0;
  end
endmodule

// File: tb/tb_lsu_mc.sv
// tb_lsu_mc: directed bench for lsu_mc with a byte-level reference model and per-cycle compare.
module tb_lsu_mc;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0, rst_ = 1'b1;
  logic        req_valid = 0, req_we = 0, req_se = 0, mem_ack = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
  logic        req_ready, rsp_valid, rsp_fault, mem_req, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  lsu_mc #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_(rst_), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_se(req_se), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;
  bit busy = 0, beat_act = 0, rsp_due = 0;
  int beat_idx = 0, nbeats = 0;
  logic [31:0] exp_addr [2], exp_wd [2];
  logic [3:0]  exp_be [2];
  logic        exp_we, exp_fault;
  logic [31:0] exp_rdata;
  logic [31:0] last_addr [2], last_wd [2], last_rdata;
  logic [3:0]  last_be [2];
  logic        last_fault, prev_req = 0;
  int rise_cyc = -1, rsp_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Byte-by-byte reference: which lanes each beat touches and what the response must be.
  task automatic model(input logic we, input logic [1:0] size, input logic se,
                       input logic [31:0] addr, wd, rd0, rd1);
    int nb, off, lane, b, l;
    logic [31:0] r, src;
    nb = 1 << size;
    off = int'(addr[1:0]);
    exp_we = we;
    exp_fault = size == 2'd3 || (!SPLIT && off + nb > 4);
    nbeats = exp_fault ? 0 : (off + nb > 4 ? 2 : 1);
    r = 0;
    for (int k = 0; k < 2; k++) begin
      exp_addr[k] = (addr & ~32'h3) + 32'(4 * k);
      exp_be[k] = 0;
      exp_wd[k] = 0;
    end
    if (!exp_fault) begin
      for (int i = 0; i < nb; i++) begin
        lane = off + i;
        b = lane / 4;
        l = lane % 4;
        exp_be[b][l] = 1'b1;
        exp_wd[b][8*l +: 8] = wd[8*i +: 8];
        src = b == 0 ? rd0 : rd1;
        r[8*i +: 8] = src[8*l +: 8];
      end
      if (se && r[8*nb-1])
        for (int i = nb; i < 4; i++) r[8*i +: 8] = 8'hFF;
    end
    exp_rdata = (we || exp_fault) ? 32'h0 : r;
  endtask

  always @(negedge clk) begin
    if (!rst_) begin
      chk("req_ready", {63'b0, req_ready}, {63'b0, !busy});
      chk("mem_req", {63'b0, mem_req}, {63'b0, beat_act});
      if (beat_act && mem_req) begin
        chk("mem_addr", mem_addr, exp_addr[beat_idx]);
        chk("mem_be", mem_be, exp_be[beat_idx]);
        chk("mem_we", mem_we, exp_we);
        chk("mem_wdata", mem_wdata, exp_wd[beat_idx]);
        last_addr[beat_idx] = mem_addr;
        last_be[beat_idx] = mem_be;
        last_wd[beat_idx] = mem_wdata;
      end
      chk("rsp_valid", {63'b0, rsp_valid}, {63'b0, rsp_due});
      if (rsp_due && rsp_valid) begin
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_fault", rsp_fault, exp_fault);
        last_rdata = rsp_rdata;
        last_fault = rsp_fault;
        rsp_cyc = cyc;
      end
      if (mem_req && !prev_req) rise_cyc = cyc;
      prev_req = mem_req;
    end
  end

  task automatic access(input logic we, input logic [1:0] size, input logic se,
                        input logic [31:0] addr, wd, rd0, rd1, input int waits);
    int t;
    t = 0;
    while (!req_ready && t < 20) begin step(); t++; end
    if (!req_ready) chk("ready_timeout", {63'b0, req_ready}, 64'd1);
    model(we, size, se, addr, wd, rd0, rd1);
    req_valid = 1; req_we = we; req_size = size; req_se = se; req_addr = addr; req_wdata = wd;
    step();
    req_valid = 0;
    busy = 1;
    if (exp_fault) rsp_due = 1;
    else begin
      beat_act = 1;
      beat_idx = 0;
      for (int b = 0; b < nbeats; b++) begin
        repeat (waits) step();
        mem_ack = 1;
        mem_rdata = b == 0 ? rd0 : rd1;
        step();
        mem_ack = 0;
        mem_rdata = 0;
        if (b == nbeats - 1) begin beat_act = 0; rsp_due = 1; end
        else beat_idx = b + 1;
      end
    end
    step();
    rsp_due = 0;
    busy = 0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst_req_ready", {63'b0, req_ready}, 64'd0);
    chk("rst_mem_req", {63'b0, mem_req}, 64'd0);
    chk("rst_mem_bus", {mem_addr, mem_wdata}, 64'd0);
    chk("rst_mem_be_we", {59'b0, mem_be, mem_we}, 64'd0);
    chk("rst_rsp", {rsp_rdata, 30'b0, rsp_valid, rsp_fault}, 64'd0);
    repeat (3) step();
    rst_ = 0;
    step();

    access(0, 2'd2, 0, 32'h10, 0, 32'h8000_00FF, 0, 3);
    chk("t1_be", last_be[0], 4'b1111);
    chk("t1_addr", last_addr[0], 32'h10);
    chk("t1_rdata", last_rdata, 32'h8000_00FF);
    chk("t1_latency", 64'(rsp_cyc - rise_cyc), 64'd4);

    access(0, 2'd0, 1, 32'h13, 0, 32'h80AA_BBCC, 0, 1);
    chk("t2_be", last_be[0], 4'b1000);
    chk("t2_rdata_se", last_rdata, 32'hFFFF_FF80);
    access(0, 2'd0, 0, 32'h13, 0, 32'h80AA_BBCC, 0, 0);
    chk("t2_rdata_ze", last_rdata, 32'h0000_0080);

    access(1, 2'd1, 0, 32'h06, 32'h0000_1234, 0, 0, 0);
    chk("t3_be", last_be[0], 4'b1100);
    chk("t3_wdata", last_wd[0], 32'h1234_0000);
    chk("t3_rsp", {last_rdata, 31'b0, last_fault}, 64'd0);

    rise_cyc = -1;
    access(0, 2'd2, 0, 32'h0E, 0, 32'hDDCC_1111, 32'h2222_BBAA, 1);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("t4_addrs", {last_addr[0], last_addr[1]}, {32'h0C, 32'h10});
    chk("t4_bes", {56'b0, last_be[0], last_be[1]}, {56'b0, 4'b1100, 4'b0011});
    chk("t4_rdata", last_rdata, 32'hBBAA_DDCC);
`else
    chk("t4_no_beat", 64'(rise_cyc), 64'(-1));
    chk("t4_fault", {31'b0, last_fault, last_rdata}, {31'b0, 1'b1, 32'h0});
`endif

    access(1, 2'd2, 0, 32'hFFFF_FFFE, 32'h1122_3344, 0, 0, 2);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("t5_wrap_addr", last_addr[1], 32'h0);
    chk("t5_wdata", {last_wd[0], last_wd[1]}, {32'h3344_0000, 32'h0000_1122});
`else
    chk("t5_fault", {63'b0, last_fault}, 64'd1);
`endif

    access(0, 2'd1, 1, 32'h02, 0, 32'h8001_5555, 0, 0);
    chk("t6_half_se", last_rdata, 32'hFFFF_8001);
    access(0, 2'd3, 0, 32'h00, 0, 0, 0, 0);
    chk("t7_dword_fault", {63'b0, last_fault}, 64'd1);
    access(0, 2'd1, 0, 32'h03, 0, 32'h11AA_BBCC, 32'h4433_2222, 0);

    // Reset mid-beat: memory never acknowledges, so the access must simply vanish.
    model(0, 2'd2, 0, 32'h20, 0, 0, 0);
    req_valid = 1; req_we = 0; req_size = 2'd2; req_se = 0; req_addr = 32'h20; req_wdata = 0;
    step();
    req_valid = 0; busy = 1; beat_act = 1; beat_idx = 0;
    step();
    #2;
    rst_ = 1;
    busy = 0; beat_act = 0; rsp_due = 0;
    #1;
    chk("rstmid_mem_req", {63'b0, mem_req}, 64'd0);
    chk("rstmid_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("rstmid_req_ready", {63'b0, req_ready}, 64'd0);
    step();
    step();
    rst_ = 0;
    @(negedge clk);
    chk("rstmid_ready_after", {63'b0, req_ready}, 64'd1);
    step();
    step();
    access(0, 2'd0, 0, 32'h01, 0, 32'h0000_5A00, 0, 0);
    chk("t9_recover", last_rdata, 32'h0000_005A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
